// File: rtl/gcd_dispatch.sv
// gcd_dispatch: operand FIFO and issue front-end for the gcd2 core.
// Queues operand pairs, issues them one at a time with a one-cycle start pulse,
// captures each core result into a ready/valid slot with a sequence tag, and
// aborts the core through a watchdog if a run takes too long.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand push handshake, in_a/in_b operands
//   gcd_rst/gcd_start         core reset (rst or abort pulse), one-cycle start
//   gcd_a/gcd_b               registered operands to the core
//   gcd_valid/gcd_out         one-cycle core result strobe and value
//   res_valid/res_ready       result slot handshake
//   res_gcd/res_tag/res_err   result value, sequence tag, watchdog-abort flag
`timescale 1ns/1ps
module gcd_dispatch #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 8,
   parameter int TIMEOUT = 200000,
   parameter int TO_W    = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic             gcd_rst,
   output logic             gcd_start,
   output logic [15:0]      gcd_a,
   output logic [15:0]      gcd_b,
   input  logic             gcd_valid,
   input  logic [15:0]      gcd_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res_gcd,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = TAG_W + 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [TAG_W-1:0] tag_q;
   logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
   logic [TO_W-1:0]  wd_q, wd_d;
   logic             abort_q, abort_d;
   logic             start_q, start_d;
   logic [15:0]      a_q, a_d, b_q, b_d;
   logic             rv_q, rv_d;
   logic [15:0]      rg_q, rg_d;
   logic [TAG_W-1:0] rt_q, rt_d;
   logic             re_q, re_d;

   logic          empty, full, push, pop, wd_hit;
   logic [EW-1:0] head;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = in_valid && !full;
   // Issue only into an empty result slot: the core strobe cannot be stalled.
   assign pop   = (state_q == IDLE) && !empty && !rv_q;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];
   assign wd_hit = (wd_q == TO_W'(TIMEOUT - 1));

   assign in_ready  = !full;
   assign gcd_rst   = rst | abort_q;
   assign gcd_start = start_q;
   assign gcd_a     = a_q;
   assign gcd_b     = b_q;
   assign res_valid = rv_q;
   assign res_gcd   = rg_q;
   assign res_tag   = rt_q;
   assign res_err   = re_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {tag_q, in_a, in_b};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         tag_q     <= '0;
         cur_tag_q <= '0;
         wd_q      <= '0;
         abort_q   <= 1'b0;
         start_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         rv_q      <= 1'b0;
         rg_q      <= '0;
         rt_q      <= '0;
         re_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            tag_q    <= tag_q + TAG_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
         cur_tag_q <= cur_tag_d;
         wd_q      <= wd_d;
         abort_q   <= abort_d;
         start_q   <= start_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rv_q      <= rv_d;
         rg_q      <= rg_d;
         rt_q      <= rt_d;
         re_q      <= re_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (pop) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (gcd_valid || wd_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur_tag_d = cur_tag_q;
      wd_d      = wd_q;
      abort_d   = 1'b0;
      start_d   = 1'b0;
      a_d       = a_q;
      b_d       = b_q;
      rv_d      = rv_q;
      rg_d      = rg_q;
      rt_d      = rt_q;
      re_d      = re_q;
      if (rv_q && res_ready) begin
         rv_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               cur_tag_d = head[EW-1:32];
               a_d       = head[31:16];
               b_d       = head[15:0];
               start_d   = 1'b1;
            end
         end
         ISSUE: begin
            wd_d = '0;
         end
         WAIT: begin
            if (gcd_valid) begin
               rg_d = gcd_out;
               rt_d = cur_tag_q;
               re_d = 1'b0;
               rv_d = 1'b1;
            end else if (wd_hit) begin
               rg_d    = '0;
               rt_d    = cur_tag_q;
               re_d    = 1'b1;
               rv_d    = 1'b1;
               abort_d = 1'b1;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: randomized bench for gcd_dispatch with a behavioural gcd2
// core model and a queue-based scoreboard of expected tagged results.
`timescale 1ns/1ps
module tb_gcd_dispatch;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 8;
   localparam int TIMEOUT = 100;
   localparam int TO_W    = 18;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_a, in_b;
   logic             gcd_rst, gcd_start;
   logic [15:0]      gcd_a, gcd_b;
   logic             gcd_valid = 1'b0;
   logic [15:0]      gcd_out = 16'd0;
   logic             res_valid, res_ready;
   logic [15:0]      res_gcd;
   logic [TAG_W-1:0] res_tag;
   logic             res_err;

   gcd_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .gcd_rst(gcd_rst), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
      .gcd_valid(gcd_valid), .gcd_out(gcd_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_gcd(res_gcd), .res_tag(res_tag), .res_err(res_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]      g;
      logic [TAG_W-1:0] tag;
      logic             err;
   } res_t;

   res_t exp_q[$];
   res_t obs_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   starts = 0;
   int   rst_pulses = 0;
   logic [TAG_W-1:0] model_tag = '0;
   bit   core_hang = 0;
   bit   stray = 0;

   function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] x, y, t;
      if (a == 16'd0 || b == 16'd0) return 16'd0;
      x = a;
      y = b;
      while (y != 16'd0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // gcd2 core model: random latency, optional hang, optional stray strobe.
   int          c_cnt = 0;
   bit          c_busy = 0;
   logic [15:0] c_res = 16'd0;
   always @(posedge clk) begin
      gcd_valid <= 1'b0;
      if (gcd_rst) begin
         c_busy <= 0;
      end else if (gcd_start) begin
         c_busy <= 1;
         c_cnt  <= int'($urandom_range(8, 1));
         c_res  <= ref_gcd(gcd_a, gcd_b);
      end else if (c_busy && !core_hang) begin
         if (c_cnt <= 1) begin
            gcd_valid <= 1'b1;
            gcd_out   <= c_res;
            c_busy    <= 0;
         end else begin
            c_cnt <= c_cnt - 1;
         end
      end else if (!c_busy && stray) begin
         gcd_valid <= 1'b1;
         gcd_out   <= 16'hdead;
      end
   end

   always @(posedge clk) begin
      if (gcd_start) starts = starts + 1;
      if (gcd_rst && !rst) rst_pulses = rst_pulses + 1;
      if (res_valid && res_ready) obs_q.push_back({res_gcd, res_tag, res_err});
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic push(input logic [15:0] a, input logic [15:0] b, input bit err);
      int k = 0;
      @(negedge clk);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      while (!in_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_wait: in_ready=%0d, want 1", in_ready);
      end else begin
         @(posedge clk);
         exp_q.push_back({err ? 16'd0 : ref_gcd(a, b), model_tag, err});
         model_tag = model_tag + 1'b1;
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_results(input int n, output bit ok);
      int k = 0;
      while (obs_q.size() < n && k < 5000) begin
         @(negedge clk);
         k++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      model_tag = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (gcd_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_gcd_rst: got %0d, want 1", gcd_rst);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({res_valid, res_gcd, res_tag, res_err} !== '0) begin
         n_fail++;
         $display("FAIL rst_res: got v=%0d g=%0d t=%0d e=%0d, want 0", res_valid, res_gcd, res_tag, res_err);
      end
      n_checks++;
      if ({gcd_start, gcd_a, gcd_b} !== '0) begin
         n_fail++;
         $display("FAIL rst_core: got s=%0d a=%0d b=%0d, want 0", gcd_start, gcd_a, gcd_b);
      end
      n_checks++;
      if (in_ready !== 1'b1 || gcd_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: got in_ready=%0d gcd_rst=%0d, want 1/0", in_ready, gcd_rst);
      end
   endtask

   task automatic test_single();
      int s0, k;
      res_t o, e;
      res_ready = 1'b0;
      s0 = starts;
      push(16'd12, 16'd18, 0);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (gcd_start !== 1'b1 || gcd_a !== 16'd12 || gcd_b !== 16'd18) begin
         n_fail++;
         $display("FAIL t1_start: got s=%0d a=%0d b=%0d, want 1/12/18", gcd_start, gcd_a, gcd_b);
      end
      k = 0;
      while (!gcd_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (res_valid !== 1'b0 || gcd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL t1_strobe: got gcd_valid=%0d res_valid=%0d, want 1/0", gcd_valid, res_valid);
      end
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_gcd !== 16'd6 || res_tag !== '0 || res_err !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_result: got v=%0d g=%0d t=%0d e=%0d, want 1/6/0/0", res_valid, res_gcd, res_tag, res_err);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_checks++;
      if (starts - s0 != 1 || obs_q.size() != 1) begin
         n_fail++;
         $display("FAIL t1_count: got starts=%0d results=%0d, want 1/1", starts - s0, obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL t1_sb: got g=%0d t=%0d e=%0d, want g=%0d t=%0d e=%0d", o.g, o.tag, o.err, e.g, e.tag, e.err);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      res_t o, e;
      res_ready = 1'b1;
      push(16'd0, 16'd5, 0);
      push(16'd7, 16'd7, 0);
      push(16'd65535, 16'd1, 0);
      wait_results(3, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t2_wait: got %0d results, want 3", obs_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL t2_sb[%0d]: got g=%0d t=%0d e=%0d, want g=%0d t=%0d e=%0d", i, o.g, o.tag, o.err, e.g, e.tag, e.err);
         end
      end
   endtask

   task automatic test_backpressure();
      int s0, acc;
      bit ok;
      res_t o, e;
      logic [15:0] a, b;
      res_ready = 1'b0;
      s0 = starts;
      acc = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         a = 16'($urandom);
         b = 16'($urandom_range(300, 1));
         in_a = a;
         in_b = b;
         in_valid = 1'b1;
         if (in_ready) begin
            acc++;
            exp_q.push_back({ref_gcd(a, b), model_tag, 1'b0});
            model_tag = model_tag + 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (acc != DEPTH + 1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL t3_accept: got acc=%0d in_ready=%0d, want %0d/0", acc, in_ready, DEPTH + 1);
      end
      n_checks++;
      if (starts - s0 != 1) begin
         n_fail++;
         $display("FAIL t3_starts: got %0d, want 1", starts - s0);
      end
      res_ready = 1'b1;
      wait_results(DEPTH + 1, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t3_wait: got %0d results, want %0d", obs_q.size(), DEPTH + 1);
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL t3_sb[%0d]: got g=%0d t=%0d e=%0d, want g=%0d t=%0d e=%0d", i, o.g, o.tag, o.err, e.g, e.tag, e.err);
         end
      end
   endtask

   task automatic test_timeout();
      int r0;
      bit ok;
      res_t o, e;
      res_ready = 1'b1;
      core_hang = 1;
      r0 = rst_pulses;
      push(16'd65535, 16'd1, 1);
      wait_results(1, ok);
      core_hang = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (!ok || rst_pulses - r0 != 1) begin
         n_fail++;
         $display("FAIL t4_abort: got results=%0d gcd_rst_cycles=%0d, want 1/1", obs_q.size(), rst_pulses - r0);
      end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL t4_sb: got g=%0d t=%0d e=%0d, want g=%0d t=%0d e=%0d", o.g, o.tag, o.err, e.g, e.tag, e.err);
         end
      end
      @(negedge clk);
      stray = 1;
      @(negedge clk);
      stray = 0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL t4_stray: got res_valid=%0d results=%0d, want 0/0", res_valid, obs_q.size());
      end
      push(16'd9, 16'd6, 0);
      wait_results(1, ok);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e || o.g !== 16'd3) begin
            n_fail++;
            $display("FAIL t4_after: got g=%0d t=%0d e=%0d, want g=3 t=%0d e=0", o.g, o.tag, o.err, e.tag);
         end
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL t4_after_wait: got 0 results, want 1");
      end
   endtask

   task automatic test_mid_reset();
      int s0;
      bit ok;
      res_t o;
      res_ready = 1'b1;
      core_hang = 1;
      for (int i = 0; i < 4; i++) push(16'(i + 3), 16'd6, 0);
      repeat (3) @(negedge clk);
      s0 = starts;
      rst = 1'b1;
      #1;
      n_checks++;
      if (gcd_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_gcd_rst: got %0d, want 1", gcd_rst);
      end
      @(negedge clk);
      rst = 1'b0;
      core_hang = 0;
      n_checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_state: got res_valid=%0d in_ready=%0d, want 0/1", res_valid, in_ready);
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (starts != s0 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL t5_quiet: got starts=%0d results=%0d, want 0/0", starts - s0, obs_q.size());
      end
      exp_q.delete();
      obs_q.delete();
      model_tag = '0;
      push(16'd20, 16'd8, 0);
      wait_results(1, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t5_wait: got 0 results, want 1");
      end else begin
         o = obs_q.pop_front();
         void'(exp_q.pop_front());
         if (o.g !== 16'd4 || o.tag !== '0 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_tag: got g=%0d t=%0d e=%0d, want 4/0/0", o.g, o.tag, o.err);
         end
      end
   endtask

   task automatic test_tag_wrap();
      bit ok;
      int nf;
      res_t o, e;
      do_reset();
      res_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         push(16'($urandom), 16'($urandom_range(65535, 0)), 0);
      end
      wait_results(257, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t6_wait: got %0d results, want 257", obs_q.size());
      end
      nf = 0;
      for (int i = 0; i < 257; i++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            nf++;
            if (nf < 10) $display("FAIL t6_sb[%0d]: got g=%0d t=%0d e=%0d, want g=%0d t=%0d e=%0d", i, o.g, o.tag, o.err, e.g, e.tag, e.err);
         end
         if (i == 256) begin
            n_checks++;
            if (o.tag !== '0) begin
               n_fail++;
               $display("FAIL t6_wrap: got tag=%0d, want 0", o.tag);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      res_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_mid_reset();
      test_tag_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
